param_pipe_adder: RTL and testbench
===================================

PARAM_PIPE_ADDER -- requirements
Module: param_pipe_adder

Interface
REQ-001 The block SHALL take parameter WIDTH, default 64, as the operand and result width in bits.
REQ-002 The block SHALL take parameter STAGES, default 4, as the number of pipeline stages (carry-chain slices).
REQ-003 The block SHALL have port clk_pi, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n_pi, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port A_pi, input, WIDTH bits: operand A.
REQ-006 The block SHALL have port B_pi, input, WIDTH bits: operand B.
REQ-007 The block SHALL have port cin_pi, input, 1 bit: carry-in; ignored when op_pi=1.
REQ-008 The block SHALL have port op_pi, input, 1 bit: 0=add, 1=subtract; present only with PIPE_ADDER_SUB_EN.
REQ-009 The block SHALL have port valid_pi, input, 1 bit: input operands valid.
REQ-010 The block SHALL have port ready_po, output, 1 bit: block accepts the input this cycle.
REQ-011 The block SHALL have port result_po, output, WIDTH bits: sum or difference.
REQ-012 The block SHALL have port carry_po, output, 1 bit: carry-out of the MSB (subtract: 1 = no borrow).
REQ-013 The block SHALL have port overflow_po, output, 1 bit: two's-complement signed overflow.
REQ-014 The block SHALL have port valid_po, output, 1 bit: result_po, carry_po and overflow_po are valid.
REQ-015 The block SHALL have port ready_pi, input, 1 bit: the downstream consumer accepts the output.

Function
REQ-016 The block SHALL reject, at elaboration, any STAGES < 1 or any WIDTH not divisible by STAGES; slice width SW = WIDTH/STAGES.
REQ-017 An input transfer SHALL occur when valid_pi && ready_po; an output transfer SHALL occur when valid_po && ready_pi.
REQ-018 The pipeline advance enable SHALL be adv = ready_pi || !valid_po, with ready_po = adv (global stall, no bubble collapse).
REQ-019 Stage k (0..STAGES-1) SHALL add operand slice k plus the registered carry from stage k-1 (stage 0: cin_pi, or 1 when subtracting).
REQ-020 Upper operand slices SHALL be delayed (skewed) and completed lower result slices delayed (deskewed), so all slices of one transfer reach the output together.
REQ-021 Latency SHALL be exactly STAGES cycles from the input transfer to valid_po with no stall; throughput SHALL be 1 result per cycle.
REQ-022 While adv=0, all pipeline registers, including valid bits and outputs, SHALL hold their values unchanged.
REQ-023 overflow_po SHALL be the MSB carry-in XOR the MSB carry-out of the final slice; carry_po SHALL be the MSB carry-out.
REQ-024 Results SHALL wrap modulo 2^WIDTH; results SHALL leave in input order with none lost or duplicated.
REQ-025 A cycle with valid_pi=0 and adv=1 SHALL insert a bubble (valid bit 0) and SHALL NOT corrupt adjacent data.

Reset
REQ-026 With rst_n_pi=0 at a clock edge, all stage valid bits, valid_po, result_po, carry_po and overflow_po SHALL become 0; reset SHALL dominate adv.
REQ-027 Reset mid-operation SHALL discard all in-flight transfers; none SHALL appear after reset releases.
REQ-028 ready_po SHALL be 1 in the first cycle after reset release.

Configuration
REQ-029 With PIPE_ADDER_SUB_EN defined, op_pi SHALL exist and op_pi=1 SHALL compute A_pi + ~B_pi + 1, with op_pi travelling in the pipeline alongside its operands.
REQ-030 Without PIPE_ADDER_SUB_EN, op_pi SHALL be absent and the block SHALL always compute A_pi + B_pi + cin_pi.

Structure
REQ-031 Package param_adder_pkg SHALL hold the default WIDTH/STAGES constants and the op enum (OP_ADD, OP_SUB).
REQ-032 The combinational slice adder SHALL be a sub-module rca_slice (parameter SW; inputs a, b, cin; outputs sum, cout, msb carry-in), instantiated STAGES times.

Verification (WIDTH=64, STAGES=4)
REQ-033 Scenario 1: A=0xFFFF_FFFF_FFFF_FFFF, B=0, cin=1 -> exactly 4 cycles later result=0, carry=1, overflow=0.
REQ-034 Scenario 2: A=0x7FFF_FFFF_FFFF_FFFF, B=1, cin=0 -> result=0x8000_0000_0000_0000, carry=0, overflow=1.
REQ-035 Scenario 3: A=0x0000_0000_0000_FFFF, B=1 (slice-boundary carry) -> result=0x0000_0000_0001_0000.
REQ-036 Scenario 4: stream 10 random pairs back-to-back, ready_pi=0 for 3 cycles mid-stream -> ready_po=0 during the stall, all 10 sums correct and in order, outputs stable while stalled.
REQ-037 Scenario 5: accept 2 transfers, then rst_n_pi=0 for 1 cycle -> valid_po=0 the next cycle and no pre-reset result emerges.
REQ-038 Scenario 6 (PIPE_ADDER_SUB_EN): A=5, B=7, op=1 -> result=0xFFFF_FFFF_FFFF_FFFE, carry=0, overflow=0.

Source files
------------

// File: rtl/param_adder_pkg.sv
// Shared constants and types for the pipelined adder.
package param_adder_pkg;

  localparam int DEF_WIDTH  = 64;
  localparam int DEF_STAGES = 4;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

endpackage

// File: rtl/param_pipe_adder_rca_slice.sv
// Combinational ripple-carry slice; exposes the carry into its MSB for overflow detection.
module rca_slice #(
  parameter int SW = 16
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          cin,
  output logic [SW-1:0] sum,
  output logic          cout,
  output logic          msb_cin
);

  always_comb begin
    logic c;
    sum     = '0;
    msb_cin = 1'b0;
    c       = cin;
    for (int i = 0; i < SW; i++) begin
      if (i == SW - 1) msb_cin = c;
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/param_pipe_adder.sv
// Carry-sliced pipelined adder: STAGES slices, operands skewed in, results deskewed out.
// Optional subtract support with PIPE_ADDER_SUB_EN (adds op_pi).
module param_pipe_adder
  import param_adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk_pi,
  input  logic             rst_n_pi,
  input  logic [WIDTH-1:0] A_pi,
  input  logic [WIDTH-1:0] B_pi,
  input  logic             cin_pi,
`ifdef PIPE_ADDER_SUB_EN
  input  logic             op_pi,
`endif
  input  logic             valid_pi,
  output logic             ready_po,
  output logic [WIDTH-1:0] result_po,
  output logic             carry_po,
  output logic             overflow_po,
  output logic             valid_po,
  input  logic             ready_pi
);

  localparam int SDIV = (STAGES < 1) ? 1 : STAGES;
  localparam int SW   = WIDTH / SDIV;

  if (STAGES < 1 || (WIDTH % SDIV) != 0) begin : g_bad_cfg
    $error("param_pipe_adder: STAGES must be >= 1 and divide WIDTH");
  end

  logic                         adv;
  logic [STAGES:1]              vld_pipe;
  logic [STAGES-1:0][SW-1:0]    a_sk, b_sk, b_eff, sum_w, res_sl;
  logic [STAGES-1:0]            cin_w, cout_w, c_q, op_st;
  logic                         msb_cin_last;
  logic                         ovf_q;

  // Global stall: every register in the pipe moves together or not at all.
  assign adv         = ready_pi || !valid_po;
  assign ready_po    = adv;
  assign valid_po    = vld_pipe[STAGES];
  assign result_po   = res_sl;
  assign carry_po    = c_q[STAGES-1];
  assign overflow_po = ovf_q;

`ifdef PIPE_ADDER_SUB_EN
  // op rides with its operands so each slice sees the op of the transfer it is working on.
  if (STAGES > 1) begin : g_op
    logic [STAGES-2:0] op_q;
    always_ff @(posedge clk_pi) begin
      if (!rst_n_pi) op_q <= '0;
      else if (adv) begin
        op_q[0] <= op_pi;
        for (int k = 1; k < STAGES - 1; k++) op_q[k] <= op_q[k-1];
      end
    end
    assign op_st = {op_q, op_pi};
  end else begin : g_op1
    assign op_st = op_pi;
  end
`else
  assign op_st = '0;
`endif

  for (genvar j = 0; j < STAGES; j++) begin : g_slice
    // Operand skew: slice j waits j cycles for the carry from below.
    if (j == 0) begin : g_head
      assign a_sk[0] = A_pi[SW-1:0];
      assign b_sk[0] = B_pi[SW-1:0];
`ifdef PIPE_ADDER_SUB_EN
      assign cin_w[0] = (op_st[0] == OP_SUB) ? 1'b1 : cin_pi;
`else
      assign cin_w[0] = cin_pi;
`endif
    end else begin : g_skew
      logic [j-1:0][SW-1:0] a_dly, b_dly;
      always_ff @(posedge clk_pi) begin
        if (adv) begin
          a_dly[0] <= A_pi[j*SW +: SW];
          b_dly[0] <= B_pi[j*SW +: SW];
          for (int i = 1; i < j; i++) begin
            a_dly[i] <= a_dly[i-1];
            b_dly[i] <= b_dly[i-1];
          end
        end
      end
      assign a_sk[j]  = a_dly[j-1];
      assign b_sk[j]  = b_dly[j-1];
      assign cin_w[j] = c_q[j-1];
    end

`ifdef PIPE_ADDER_SUB_EN
    assign b_eff[j] = (op_st[j] == OP_SUB) ? ~b_sk[j] : b_sk[j];
`else
    assign b_eff[j] = b_sk[j];
`endif

    if (j == STAGES - 1) begin : g_msb
      rca_slice #(.SW(SW)) u_rca (
        .a(a_sk[j]), .b(b_eff[j]), .cin(cin_w[j]),
        .sum(sum_w[j]), .cout(cout_w[j]), .msb_cin(msb_cin_last)
      );
    end else begin : g_mid
      logic mcin_unused;
      rca_slice #(.SW(SW)) u_rca (
        .a(a_sk[j]), .b(b_eff[j]), .cin(cin_w[j]),
        .sum(sum_w[j]), .cout(cout_w[j]), .msb_cin(mcin_unused)
      );
    end

    // Result deskew: slice j holds its sum STAGES-j cycles so all slices exit together.
    logic [STAGES-j-1:0][SW-1:0] r_q;
    always_ff @(posedge clk_pi) begin
      if (!rst_n_pi) r_q <= '0;
      else if (adv) begin
        r_q[0] <= sum_w[j];
        for (int i = 1; i < STAGES - j; i++) r_q[i] <= r_q[i-1];
      end
    end
    assign res_sl[j] = r_q[STAGES-j-1];
  end

  always_ff @(posedge clk_pi) begin
    if (!rst_n_pi) begin
      vld_pipe <= '0;
      c_q      <= '0;
      ovf_q    <= 1'b0;
    end else if (adv) begin
      vld_pipe[1] <= valid_pi;
      for (int k = 2; k <= STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
      c_q   <= cout_w;
      ovf_q <= msb_cin_last ^ cout_w[STAGES-1];
    end
  end

endmodule

// File: tb/tb_param_pipe_adder.sv
// Directed bench for param_pipe_adder (WIDTH=64, STAGES=4); subtract case under PIPE_ADDER_SUB_EN.
module tb_param_pipe_adder;

  localparam int W = 64;
  localparam int S = 4;

  logic         clk_pi = 1'b0;
  logic         rst_n_pi, cin_pi, valid_pi, ready_pi;
  logic [W-1:0] A_pi, B_pi;
  logic         ready_po, carry_po, overflow_po, valid_po;
  logic [W-1:0] result_po;
`ifdef PIPE_ADDER_SUB_EN
  logic         op_pi;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk_pi = ~clk_pi;

  param_pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk_pi(clk_pi), .rst_n_pi(rst_n_pi),
    .A_pi(A_pi), .B_pi(B_pi), .cin_pi(cin_pi),
`ifdef PIPE_ADDER_SUB_EN
    .op_pi(op_pi),
`endif
    .valid_pi(valid_pi), .ready_po(ready_po),
    .result_po(result_po), .carry_po(carry_po), .overflow_po(overflow_po),
    .valid_po(valid_po), .ready_pi(ready_pi)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_pi);
    #1;
  endtask

  // One isolated transfer; checks exact latency and the full output word.
  task automatic send(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic [W-1:0] er, input logic ec, input logic eo);
    A_pi = a; B_pi = b; cin_pi = cin; valid_pi = 1'b1;
    step();
    valid_pi = 1'b0;
    for (int i = 1; i < S; i++) begin
      check({tag, "_lat"}, W'(valid_po), W'(0));
      step();
    end
    check({tag, "_vld"}, W'(valid_po), W'(1));
    check({tag, "_res"}, result_po, er);
    check({tag, "_cy"},  W'(carry_po), W'(ec));
    check({tag, "_ov"},  W'(overflow_po), W'(eo));
    step();
    check({tag, "_drain"}, W'(valid_po), W'(0));
  endtask

  logic [W-1:0] sa [10];
  logic [W-1:0] sb [10];
  logic [W-1:0] se [10];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] snap;
    int ii, oi, cyc;

    sa = '{64'd1, 64'h10, 64'hFFFF_FFFF, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h0000_FFFF_0000_FFFF, 64'h8000_0000_0000_0000, 64'd100,
           64'hAAAA_AAAA_AAAA_AAAA, 64'h0123_4567_89AB_CDEF};
    sb = '{64'd2, 64'h20, 64'd1, 64'h1111_1111_1111_1111, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h0000_0001_0000_0001, 64'h8000_0000_0000_0000, 64'd200,
           64'h5555_5555_5555_5555, 64'd0};
    se = '{64'd3, 64'h30, 64'h1_0000_0000, 64'h2345_6789_ABCD_F001, 64'hFFFF_FFFF_FFFF_FFFE,
           64'h0001_0000_0001_0000, 64'd0, 64'd300,
           64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF};

    rst_n_pi = 1'b0; valid_pi = 1'b0; ready_pi = 1'b1;
    A_pi = '0; B_pi = '0; cin_pi = 1'b0;
`ifdef PIPE_ADDER_SUB_EN
    op_pi = 1'b0;
`endif
    step();
    step();
    check("rst_vld", W'(valid_po), W'(0));
    check("rst_res", result_po, W'(0));
    check("rst_cy",  W'(carry_po), W'(0));
    check("rst_ov",  W'(overflow_po), W'(0));
    rst_n_pi = 1'b1;
    #1;
    check("rst_rdy", W'(ready_po), W'(1));
    step();

    send("s1_wrap",  64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0);
    send("s2_ovf",   64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    send("s3_slice", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0);
    send("ones_cin", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
         64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    send("neg_ovf",  64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 1'b1, 1'b1);

    // Back-to-back stream with a 3-cycle downstream stall once results are flowing.
    ii = 0; oi = 0; cyc = 0; snap = '0;
    while (oi < 10 && cyc < 60) begin
      ready_pi = !(cyc >= 6 && cyc <= 8);
      if (ii < 10) begin
        valid_pi = 1'b1; A_pi = sa[ii]; B_pi = sb[ii]; cin_pi = 1'b0;
      end else begin
        valid_pi = 1'b0;
      end
      #1;
      if (!ready_pi) begin
        check("stall_rdy", W'(ready_po), W'(0));
        check("stall_vld", W'(valid_po), W'(1));
        if (cyc == 6) snap = result_po;
        else          check("stall_hold", result_po, snap);
      end
      if (valid_po && ready_pi) begin
        check($sformatf("stream%0d", oi), result_po, se[oi]);
        oi++;
      end
      if (valid_pi && ready_po) ii++;
      step();
      cyc++;
    end
    check("stream_count", W'(oi), W'(10));
    valid_pi = 1'b0; ready_pi = 1'b1;
    step();
    check("stream_drain", W'(valid_po), W'(0));

    // Reset with two transfers in flight: nothing from before reset may emerge.
    A_pi = 64'd1; B_pi = 64'd1; cin_pi = 1'b0; valid_pi = 1'b1;
    step();
    A_pi = 64'd2;
    step();
    valid_pi = 1'b0; rst_n_pi = 1'b0;
    step();
    rst_n_pi = 1'b1;
    #1;
    check("s5_vld", W'(valid_po), W'(0));
    check("s5_res", result_po, W'(0));
    check("s5_rdy", W'(ready_po), W'(1));
    for (int i = 0; i < 6; i++) begin
      step();
      check("s5_flush", W'(valid_po), W'(0));
    end

`ifdef PIPE_ADDER_SUB_EN
    op_pi = 1'b1;
    send("s6_sub", 64'd5, 64'd7, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    op_pi = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
